cic_interp_stages: RTL and testbench

- I/Q cascaded-integrator-comb interpolator; mirror of the decimating CIC on the transmit path.
- Low-rate samples enter through a valid/ready handshake and pass through STAGES comb stages.
- Each sample is then zero-stuffed by FACTOR on a high-rate output strobe and integrated through STAGES integrators.
- Sits between baseband sample sources and the DAC/upconversion path; the output rate is set entirely by i_strobe.

---
 rtl/cic_interp_stages.sv | 201 ++++++++++++++++++++
 tb/tb_cic_interp_stages.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cic_interp_stages.sv
// cic_interp_stages: I/Q CIC interpolator.
// Low-rate samples enter through a valid/ready handshake and pass through a
// comb chain. Each comb-chain output is parked in a one-entry hold register.
// On every high-rate i_strobe, the upsampler emits either the held sample
// (phase 0) or a zero. The result is then integrated by the integrator chain.
// All arithmetic is WIDTH-bit two's complement and wraps.
// Optional feature macro: CIC_INTERP_UNDERRUN_EN adds the o_underrun pulse
// output. The datapath is unchanged by it.
module cic_interp_stages #(
  parameter int WIDTH  = 16,
  parameter int FACTOR = 313,
  parameter int DELAY  = 2,
  parameter int STAGES = 5
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_inph_data,
  input  logic [WIDTH-1:0] i_quad_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_strobe,
  output logic [WIDTH-1:0] o_inph_data,
  output logic [WIDTH-1:0] o_quad_data,
  output logic             o_valid
`ifdef CIC_INTERP_UNDERRUN_EN
  ,
  output logic             o_underrun
`endif
);

  localparam int PW = (FACTOR > 1) ? $clog2(FACTOR) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(FACTOR - 1);
  localparam logic [PW-1:0] PHASE_ONE  = (FACTOR > 1) ? PW'(1) : PW'(0);

  logic              xfer_s;
  logic [STAGES-1:0] comb_v_s;
  logic              chain_v_s;
  logic [WIDTH-1:0]  chain_i_s;
  logic [WIDTH-1:0]  chain_q_s;

  logic              hold_full_r;
  logic [WIDTH-1:0]  hold_i_r;
  logic [WIDTH-1:0]  hold_q_r;
  logic [PW-1:0]     phase_r;
  logic              up_v_r;
  logic [WIDTH-1:0]  up_i_r;
  logic [WIDTH-1:0]  up_q_r;

  // Ready depends only on state: the hold register must be empty and the
  // comb chain idle. i_valid and i_strobe are not part of this expression.
  assign o_ready = !i_reset && !hold_full_r && !(|comb_v_s);
  assign xfer_s  = i_valid && o_ready;

  // Comb chain: y[n] = x[n] - x[n-DELAY]. Each stage advances only on its
  // input valid.
  for (genvar k = 0; k < STAGES; k++) begin : g_comb
    logic [WIDTH-1:0] x_i_s;
    logic [WIDTH-1:0] x_q_s;
    logic             x_v_s;
    logic [WIDTH-1:0] y_i_r;
    logic [WIDTH-1:0] y_q_r;
    logic             v_r;
    logic [WIDTH-1:0] dl_i_r [DELAY];
    logic [WIDTH-1:0] dl_q_r [DELAY];

    if (k == 0) begin : g_first
      assign x_i_s = i_inph_data;
      assign x_q_s = i_quad_data;
      assign x_v_s = xfer_s;
    end else begin : g_next
      assign x_i_s = g_comb[k-1].y_i_r;
      assign x_q_s = g_comb[k-1].y_q_r;
      assign x_v_s = g_comb[k-1].v_r;
    end

    assign comb_v_s[k] = v_r;

    // Comb difference and delay-line shift, gated by the stage input valid.
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        v_r   <= 1'b0;
        y_i_r <= '0;
        y_q_r <= '0;
        for (int d = 0; d < DELAY; d++) begin
          dl_i_r[d] <= '0;
          dl_q_r[d] <= '0;
        end
      end else begin
        v_r <= x_v_s;
        if (x_v_s) begin
          y_i_r     <= x_i_s - dl_i_r[DELAY-1];
          y_q_r     <= x_q_s - dl_q_r[DELAY-1];
          dl_i_r[0] <= x_i_s;
          dl_q_r[0] <= x_q_s;
          for (int d = 1; d < DELAY; d++) begin
            dl_i_r[d] <= dl_i_r[d-1];
            dl_q_r[d] <= dl_q_r[d-1];
          end
        end
      end
    end
  end

  assign chain_v_s = g_comb[STAGES-1].v_r;
  assign chain_i_s = g_comb[STAGES-1].y_i_r;
  assign chain_q_s = g_comb[STAGES-1].y_q_r;

  // Hold register and zero-stuffing upsampler stepped by i_strobe.
  // A consume in the same cycle as a load lets the clear win; in practice
  // ready gating keeps the two apart.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      hold_full_r <= 1'b0;
      hold_i_r    <= '0;
      hold_q_r    <= '0;
      phase_r     <= '0;
      up_v_r      <= 1'b0;
      up_i_r      <= '0;
      up_q_r      <= '0;
    end else begin
      up_v_r <= i_strobe;
      if (chain_v_s) begin
        hold_i_r    <= chain_i_s;
        hold_q_r    <= chain_q_s;
        hold_full_r <= 1'b1;
      end
      if (i_strobe) begin
        if (phase_r == PW'(0)) begin
          if (hold_full_r) begin
            up_i_r      <= hold_i_r;
            up_q_r      <= hold_q_r;
            hold_full_r <= 1'b0;
            phase_r     <= PHASE_ONE;
          end else begin
            up_i_r <= '0;
            up_q_r <= '0;
          end
        end else begin
          up_i_r  <= '0;
          up_q_r  <= '0;
          phase_r <= (phase_r == PHASE_LAST) ? PW'(0) : phase_r + PW'(1);
        end
      end
    end
  end

`ifdef CIC_INTERP_UNDERRUN_EN
  logic underrun_r;

  // One-cycle pulse after a phase-0 strobe that finds the hold register empty.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= i_strobe && (phase_r == PW'(0)) && !hold_full_r;
    end
  end

  assign o_underrun = underrun_r;
`endif

  // Integrator chain: acc <= acc + x on input valid, with modular wrap.
  for (genvar k = 0; k < STAGES; k++) begin : g_int
    logic [WIDTH-1:0] x_i_s;
    logic [WIDTH-1:0] x_q_s;
    logic             x_v_s;
    logic [WIDTH-1:0] acc_i_r;
    logic [WIDTH-1:0] acc_q_r;
    logic             v_r;

    if (k == 0) begin : g_first
      assign x_i_s = up_i_r;
      assign x_q_s = up_q_r;
      assign x_v_s = up_v_r;
    end else begin : g_next
      assign x_i_s = g_int[k-1].acc_i_r;
      assign x_q_s = g_int[k-1].acc_q_r;
      assign x_v_s = g_int[k-1].v_r;
    end

    // Accumulate on input valid; the valid travels one stage per cycle.
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        v_r     <= 1'b0;
        acc_i_r <= '0;
        acc_q_r <= '0;
      end else begin
        v_r <= x_v_s;
        if (x_v_s) begin
          acc_i_r <= acc_i_r + x_i_s;
          acc_q_r <= acc_q_r + x_q_s;
        end
      end
    end
  end

  assign o_inph_data = g_int[STAGES-1].acc_i_r;
  assign o_quad_data = g_int[STAGES-1].acc_q_r;
  assign o_valid     = g_int[STAGES-1].v_r;

endmodule

// File: tb/tb_cic_interp_stages.sv
// Scoreboard bench for cic_interp_stages with WIDTH=8, STAGES=1, DELAY=2,
// FACTOR=4. With one comb of delay 2 and one integrator, each output equals
// the most recently consumed sample plus the one before it (mod 256), held
// across the four strobes of its period. Underruns leave the output unchanged.
module tb_cic_interp_stages;

  logic       clk;
  logic       i_reset;
  logic [7:0] i_inph_data;
  logic [7:0] i_quad_data;
  logic       i_valid;
  logic       o_ready;
  logic       i_strobe;
  logic [7:0] o_inph_data;
  logic [7:0] o_quad_data;
  logic       o_valid;
`ifdef CIC_INTERP_UNDERRUN_EN
  logic       o_underrun;
`endif

  cic_interp_stages #(
    .WIDTH(8), .FACTOR(4), .DELAY(2), .STAGES(1)
  ) dut (
    .i_clock    (clk),
    .i_reset    (i_reset),
    .i_inph_data(i_inph_data),
    .i_quad_data(i_quad_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_strobe   (i_strobe),
    .o_inph_data(o_inph_data),
    .o_quad_data(o_quad_data),
    .o_valid    (o_valid)
`ifdef CIC_INTERP_UNDERRUN_EN
    ,
    .o_underrun (o_underrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_q [$];
  logic        mon_en   = 1'b0;
  logic        ur_flag  = 1'b0;
  logic [7:0]  isamp [12];
  logic [7:0]  qsamp [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected {I,Q} for strobe s of a stream (strobe every cycle from phase 0).
  function automatic logic [15:0] exp_val(input int base, input int nsamp, input int s,
                                          input logic [7:0] ai, input logic [7:0] aq,
                                          input logic [7:0] pi, input logic [7:0] pq);
    int k;
    logic [7:0] ci, cq;
    if (nsamp == 0 || s < 2) return {ai, aq};
    k = (s - 2) / 4;
    if (k > nsamp - 1) k = nsamp - 1;
    ci = isamp[base+k] + ((k > 0) ? isamp[base+k-1] : pi);
    cq = qsamp[base+k] + ((k > 0) ? qsamp[base+k-1] : pq);
    return {ci, cq};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      i_strobe = 1'b0;
      i_valid  = 1'b0;
      ur_flag  = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Strobe every cycle and offer samples base..base+nsamp-1 with i_valid held.
  // Optionally apply a one-cycle reset at strobe index reset_at.
  task automatic stream(input int base, input int nsamp, input int nstrobe,
                        input logic [7:0] ai, input logic [7:0] aq,
                        input logic [7:0] pi, input logic [7:0] pq,
                        input int reset_at);
    int   k = 0;
    logic xfer;
    logic exp_rdy;
    for (int s = 0; s < nstrobe; s++) begin
      if (s == reset_at) begin
        i_reset  = 1'b1;
        i_valid  = 1'b0;
        i_strobe = 1'b1;
        ur_flag  = 1'b0;
        @(posedge clk); #1;
        i_reset  = 1'b0;
        i_strobe = 1'b0;
        #1;
        check("ready_after_reset", o_ready, 1);
        check("valid_after_reset", o_valid, 0);
        return;
      end
      if (nsamp == 0) exp_rdy = 1'b1;
      else exp_rdy = (s == 0) || (s >= 3 && (((s - 3) % 4) == 0 || s >= 4 * nsamp - 1));
      check($sformatf("ready_s%0d", s), o_ready, exp_rdy);
      xfer     = o_ready && (k < nsamp);
      i_valid  = (k < nsamp);
      if (k < nsamp) begin
        i_inph_data = isamp[base+k];
        i_quad_data = qsamp[base+k];
      end
      i_strobe = 1'b1;
      ur_flag  = (nsamp == 0) || (s < 2) || (s >= 2 + 4 * nsamp);
      exp_q.push_back(exp_val(base, nsamp, s, ai, aq, pi, pq));
      @(posedge clk); #1;
      if (xfer) k++;
    end
    i_valid  = 1'b0;
    i_strobe = 1'b0;
    ur_flag  = 1'b0;
    check("transfer_count", k, nsamp);
  endtask

  // Monitor: o_valid must be i_strobe delayed by two edges; data popped from
  // the scoreboard on valid, held otherwise. Reset discards in-flight work.
  initial begin
    logic        p_last = 1'b0;
    logic        p_prev = 1'b0;
    logic        u_last = 1'b0;
    logic [7:0]  last_i = 8'h00;
    logic [7:0]  last_q = 8'h00;
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("o_valid_timing", o_valid, p_prev);
        if (o_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_output: got %0h/%0h expected none", o_inph_data, o_quad_data);
          end else begin
            e = exp_q.pop_front();
            check("out_inph", o_inph_data, e[15:8]);
            check("out_quad", o_quad_data, e[7:0]);
            last_i = e[15:8];
            last_q = e[7:0];
          end
        end else begin
          check("hold_inph", o_inph_data, last_i);
          check("hold_quad", o_quad_data, last_q);
        end
`ifdef CIC_INTERP_UNDERRUN_EN
        check("o_underrun", o_underrun, u_last);
`endif
        p_prev = p_last;
        p_last = i_strobe && !i_reset;
        u_last = i_strobe && !i_reset && ur_flag;
        if (i_reset) begin
          exp_q.delete();
          last_i = 8'h00;
          last_q = 8'h00;
          p_prev = 1'b0;
          p_last = 1'b0;
          u_last = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    isamp[0] = 8'h05; qsamp[0] = 8'hFB;
    isamp[1] = 8'h7F; qsamp[1] = 8'h01;
    isamp[2] = 8'h01; qsamp[2] = 8'hFF;
    isamp[3] = 8'h80; qsamp[3] = 8'h7F;
    isamp[4] = 8'h80; qsamp[4] = 8'h40;
    isamp[5] = 8'h10; qsamp[5] = 8'hC0;
    isamp[6] = 8'hF0; qsamp[6] = 8'h11;
    isamp[7] = 8'h00; qsamp[7] = 8'h22;
    isamp[8] = 8'h11; qsamp[8] = 8'h44;
    isamp[9] = 8'h33; qsamp[9] = 8'h55;
    isamp[10] = 8'h22; qsamp[10] = 8'h9C;
    isamp[11] = 8'h00; qsamp[11] = 8'h00;

    i_reset     = 1'b1;
    i_valid     = 1'b0;
    i_strobe    = 1'b0;
    i_inph_data = 8'h00;
    i_quad_data = 8'h00;
    @(posedge clk); #1;
    mon_en = 1'b1;
    check("reset_ready", o_ready, 0);
    check("reset_valid", o_valid, 0);
    check("reset_inph", o_inph_data, 0);
    check("reset_quad", o_quad_data, 0);
    @(posedge clk); #1;
    i_reset = 1'b0;
    #1;
    check("ready_first_cycle", o_ready, 1);

    // Underrun only: outputs stay zero.
    stream(0, 0, 6, 8'h00, 8'h00, 8'h00, 8'h00, -1);
    idle(3);
    // Main stream with wrap-around values, then trailing underruns.
    stream(0, 8, 38, 8'h00, 8'h00, 8'h00, 8'h00, -1);
    idle(3);
    // Mid-stream reset while phase=3 and the hold register is full.
    stream(8, 2, 10, isamp[7] + isamp[6], qsamp[7] + qsamp[6], isamp[7], qsamp[7], 5);
    idle(2);
    // After reset, strobes give zero until a new sample arrives.
    stream(0, 0, 5, 8'h00, 8'h00, 8'h00, 8'h00, -1);
    stream(10, 1, 8, 8'h00, 8'h00, 8'h00, 8'h00, -1);
    idle(5);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
